// File: rtl/i2c_target.sv
// I2C target responder with a 7-bit address, oversampled on clk and never clocked from SCL.
// Received write bytes are strobed to the host, and read bytes are requested from it one at a time.
module i2c_target #(
  parameter logic [6:0]  ADDR     = 7'h1A,
  parameter int unsigned HOLD_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sdat,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StWrite, StWrAck, StRead, StRdAck, StIgnore
  } state_e;

  typedef enum logic [1:0] {ActRelease, ActLow, ActBit} act_e;

  state_e     state;
  act_e       act;
  logic       scl_s1, scl_s2, scl_h, sda_s1, sda_s2, sda_h;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] hold_cnt;
  logic       pend, ack_armed, rw, sda_oe;
  logic       scl_rise, scl_fall, start_det, stop_det;

  assign sdat      = sda_oe ? 1'b0 : 1'bz;
  assign scl_rise  = scl_s2 & ~scl_h;
  assign scl_fall  = ~scl_s2 & scl_h;
  assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
  assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      {scl_s1, scl_s2, scl_h} <= 3'b111;
      {sda_s1, sda_s2, sda_h} <= 3'b111;
      state     <= StIdle;
      act       <= ActRelease;
      bit_cnt   <= '0;
      shreg     <= '0;
      hold_cnt  <= '0;
      pend      <= 1'b0;
      ack_armed <= 1'b0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      wr_data   <= '0;
      wr_valid  <= 1'b0;
      rd_req    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      scl_s1   <= scl;
      scl_s2   <= scl_s1;
      scl_h    <= scl_s2;
      sda_s1   <= sdat;
      sda_s2   <= sda_s1;
      sda_h    <= sda_s2;
      wr_valid <= 1'b0;
      rd_req   <= 1'b0;
      // The host presents the read byte during the rd_req cycle.
      if (rd_req) shreg <= rd_data;
      // Deferred SDA update HOLD_CYC cycles after the synced SCL fall.
      if (pend) begin
        if (hold_cnt == 8'd1) begin
          pend <= 1'b0;
          unique case (act)
            ActLow:  sda_oe <= 1'b1;
            ActBit:  sda_oe <= ~shreg[7];
            default: sda_oe <= 1'b0;
          endcase
        end else begin
          hold_cnt <= hold_cnt - 8'd1;
        end
      end
      if (start_det || stop_det) begin
        sda_oe    <= 1'b0;
        pend      <= 1'b0;
        bit_cnt   <= '0;
        ack_armed <= 1'b0;
        busy      <= 1'b0;
        state     <= start_det ? StAddr : StIdle;
      end else begin
        unique case (state)
          StAddr: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda_s2};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                ack_armed <= 1'b0;
                if (shreg[6:0] == ADDR) begin
                  state <= StAddrAck;
                  busy  <= 1'b1;
                  rw    <= sda_s2;
                end else begin
                  state <= StIgnore;
                end
              end
            end
          end
          StAddrAck, StWrAck: begin
            if (scl_fall) begin
              pend     <= 1'b1;
              hold_cnt <= 8'(HOLD_CYC);
              if (!ack_armed) begin
                act       <= ActLow;
                ack_armed <= 1'b1;
              end else begin
                ack_armed <= 1'b0;
                bit_cnt   <= '0;
                if (state == StAddrAck && rw) begin
                  rd_req <= 1'b1;
                  act    <= ActBit;
                  state  <= StRead;
                end else begin
                  act   <= ActRelease;
                  state <= StWrite;
                end
              end
            end
          end
          StWrite: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda_s2};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                wr_data   <= {shreg[6:0], sda_s2};
                wr_valid  <= 1'b1;
                ack_armed <= 1'b0;
                state     <= StWrAck;
              end
            end
          end
          StRead: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt != 4'd0) begin
              pend     <= 1'b1;
              hold_cnt <= 8'(HOLD_CYC);
              if (bit_cnt == 4'd8) begin
                act       <= ActRelease;
                ack_armed <= 1'b0;
                state     <= StRdAck;
              end else begin
                shreg <= {shreg[6:0], 1'b0};
                act   <= ActBit;
              end
            end
          end
          StRdAck: begin
            if (scl_rise) begin
              if (!sda_s2) begin
                ack_armed <= 1'b1;
              end else begin
                state <= StIgnore;
                busy  <= 1'b0;
              end
            end else if (scl_fall && ack_armed) begin
              ack_armed <= 1'b0;
              rd_req    <= 1'b1;
              bit_cnt   <= '0;
              pend      <= 1'b1;
              hold_cnt  <= 8'(HOLD_CYC);
              act       <= ActBit;
              state     <= StRead;
            end
          end
          StIdle, StIgnore: ;
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule
